// File: rtl/dcache_pkg.sv
// Shared state encoding, byte-word type and address-geometry helpers for the write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_t;

  // Element 0 is the most significant byte, so the packed value is the big-endian word.
  typedef logic [0:3][7:0] byte_word_t;

  localparam int DEF_NUM_LINES      = 64;
  localparam int DEF_WORDS_PER_LINE = 4;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines, input int words_per_line);
    return 30 - $clog2(num_lines) - $clog2(words_per_line);
  endfunction

  localparam int OFF_W = off_w(DEF_WORDS_PER_LINE);
  localparam int IDX_W = idx_w(DEF_NUM_LINES);
  localparam int TAG_W = tag_w(DEF_NUM_LINES, DEF_WORDS_PER_LINE);

  function automatic logic [31:0] pack_word(input byte_word_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic byte_word_t unpack_word(input logic [31:0] w);
    byte_word_t b;
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    return b;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one asynchronous lookup port, one synchronous word write,
// per-line valid+tag set and single-cycle clear-all (clear-all wins over set).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int OW = off_w(WORDS_PER_LINE),
  localparam int IW = idx_w(NUM_LINES),
  localparam int TW = tag_w(NUM_LINES, WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [IW-1:0] rd_idx,
  input  logic [OW-1:0] rd_off,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [OW-1:0] wr_off,
  input  logic [31:0]   wr_data,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic [TW-1:0] set_tag,
  input  logic          clr_all
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0]        tag_q  [0:NUM_LINES-1];
  logic [31:0]          data_q [0:NUM_LINES*WORDS_PER_LINE-1];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[{rd_idx, rd_off}];

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

  // Tag and data are plain RAM; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_q[set_idx] <= set_tag;
    end
    if (wr_en) begin
      data_q[{wr_idx, wr_off}] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate D-cache: read hits are combinational,
// misses refill the line one word per mem_req/mem_ack; cpu_stall holds the core meanwhile.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [31:0]      cpu_addr,
  input  logic             cpu_rd_en,
  input  logic             cpu_wr_en,
  input  logic [0:3][7:0]  cpu_wdata,
  output logic [0:3][7:0]  cpu_rdata,
  output logic             cpu_stall,
  input  logic             flush,
  output logic [31:0]      mem_addr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [0:3][7:0]  mem_wdata,
  input  logic [0:3][7:0]  mem_rdata,
  input  logic             mem_ack
);

  localparam int OW = off_w(WORDS_PER_LINE);
  localparam int IW = idx_w(NUM_LINES);
  localparam int TW = tag_w(NUM_LINES, WORDS_PER_LINE);

  state_t        state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic          addr_ld;

  logic [OW-1:0] cpu_off, a_off, lu_off, wr_off;
  logic [IW-1:0] cpu_idx, a_idx, lu_idx;
  logic [TW-1:0] cpu_tag, a_tag, lu_tag;

  logic          arr_valid;
  logic [TW-1:0] arr_tag;
  logic [31:0]   arr_rdata, arr_wdata;
  logic          arr_wr_en, arr_set, arr_clr;
  logic          hit, stall, flush_any, last_word;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign cpu_off = cpu_addr[OW+1:2];
  assign cpu_idx = cpu_addr[OW+IW+1:OW+2];
  assign cpu_tag = cpu_addr[31:OW+IW+2];
  assign a_off   = addr_q[OW+1:2];
  assign a_idx   = addr_q[OW+IW+1:OW+2];
  assign a_tag   = addr_q[31:OW+IW+2];

  // The single lookup port follows the core in IDLE and the latched address otherwise.
  assign lu_idx = (state_q == IDLE) ? cpu_idx : a_idx;
  assign lu_off = (state_q == IDLE) ? cpu_off : a_off;
  assign lu_tag = (state_q == IDLE) ? cpu_tag : a_tag;
  assign hit    = arr_valid && (arr_tag == lu_tag);

  assign wr_off    = (state_q == REFILL) ? cnt_q : a_off;
  assign arr_wdata = (state_q == REFILL) ? pack_word(mem_rdata) : wdata_q;
  assign flush_any = flush_pend_q | flush;
  assign last_word = (cnt_q == {OW{1'b1}});

  dcache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_idx   (lu_idx),
    .rd_off   (lu_off),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_rdata),
    .wr_en    (arr_wr_en),
    .wr_idx   (a_idx),
    .wr_off   (wr_off),
    .wr_data  (arr_wdata),
    .set_en   (arr_set),
    .set_idx  (a_idx),
    .set_tag  (a_tag),
    .clr_all  (arr_clr)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    addr_ld      = 1'b0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    arr_wr_en    = 1'b0;
    arr_set      = 1'b0;
    arr_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        arr_clr = flush;
        if (cpu_wr_en) begin
          stall   = 1'b1;
          addr_ld = 1'b1;
          state_d = WRITE;
        end else if (cpu_rd_en && !(hit && !flush)) begin
          stall   = 1'b1;
          addr_ld = 1'b1;
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        stall        = 1'b1;
        mem_req      = 1'b1;
        mem_addr     = {addr_q[31:OW+2], cnt_q, 2'b00};
        flush_pend_d = flush_any;
        if (mem_ack) begin
          arr_wr_en = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (last_word) begin
            // A flush seen during the refill also drops the line just filled.
            arr_set      = !flush_any;
            arr_clr      = flush_any;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      WRITE: begin
        stall        = !mem_ack;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = {addr_q, 2'b00};
        mem_wdata    = unpack_word(wdata_q);
        flush_pend_d = flush_any;
        if (mem_ack) begin
          arr_wr_en    = hit;
          arr_clr      = flush_any;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_stall = stall && !rst_b;
  assign cpu_rdata = rst_b ? '0 : unpack_word(arr_rdata);

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      if (addr_ld) begin
        addr_q  <= cpu_addr[31:2];
        wdata_q <= pack_word(cpu_wdata);
      end
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed plus random bench for dcache_wt against a line-residency model and a reference memory.
module tb_dcache_wt;

  localparam int NL = 64;
  localparam int W  = 4;

  logic            clk;
  logic            rst_b;
  logic [31:0]     cpu_addr;
  logic            cpu_rd_en;
  logic            cpu_wr_en;
  logic [0:3][7:0] cpu_wdata;
  logic [0:3][7:0] cpu_rdata;
  logic            cpu_stall;
  logic            flush;
  logic [31:0]     mem_addr;
  logic            mem_req;
  logic            mem_we;
  logic [0:3][7:0] mem_wdata;
  logic [0:3][7:0] mem_rdata;
  logic            mem_ack;

  dcache_wt #(.NUM_LINES(NL), .WORDS_PER_LINE(W)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .cpu_addr  (cpu_addr),
    .cpu_rd_en (cpu_rd_en),
    .cpu_wr_en (cpu_wr_en),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          mem_lat  = 2;
  bit          ack_hi   = 0;
  bit          stray    = 0;
  xfer_t       xq[$];
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  bit          mvalid [NL];
  logic [31:0] mline  [NL];

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bytes_to_w(input logic [0:3][7:0] b);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[31-8*k -: 8] = b[k];
    return w;
  endfunction

  function automatic logic [0:3][7:0] w_to_bytes(input logic [31:0] w);
    logic [0:3][7:0] b;
    for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
    return b;
  endfunction

  function automatic logic [31:0] fill_pattern(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % (4 * W));
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (4 * W)) % NL);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] k;
    k = a - (a % 4);
    if (ref_mem.exists(k)) return ref_mem[k];
    return fill_pattern(k);
  endfunction

  // Memory responder: acks mem_lat cycles after a request starts, checks request stability.
  initial begin
    int          wcnt;
    bit          pend;
    logic [31:0] s_addr, s_wd, k;
    logic        s_we;
    wcnt = 0; pend = 0; s_addr = '0; s_wd = '0; s_we = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (mem_req) begin
        if (pend) begin
          chk("req_stable_addr", mem_addr, s_addr);
          chk("req_stable_we", {31'b0, mem_we}, {31'b0, s_we});
          chk("req_stable_wdata", bytes_to_w(mem_wdata), s_wd);
        end
        s_addr = mem_addr; s_we = mem_we; s_wd = bytes_to_w(mem_wdata);
        if (wcnt >= mem_lat) begin
          mem_ack = 1'b1;
          wcnt = 0;
          pend = 0;
          if (mem_we) begin
            phys_mem[mem_addr] = bytes_to_w(mem_wdata);
          end else begin
            k = mem_addr;
            mem_rdata = w_to_bytes(phys_mem.exists(k) ? phys_mem[k] : fill_pattern(k));
          end
          xq.push_back('{mem_we, mem_addr, bytes_to_w(mem_wdata)});
        end else begin
          mem_ack = ack_hi;
          wcnt++;
          pend = 1;
        end
      end else begin
        mem_ack = stray | ack_hi;
        wcnt = 0;
        pend = 0;
      end
    end
  end

  // Entered and left at posedge+1; st counts stalled cycles before the op retires.
  task automatic run_op(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int flush_at, output logic [31:0] d, output int st);
    bit done;
    done = 0; st = 0; d = '0;
    cpu_addr = a; cpu_wdata = w_to_bytes(wd);
    cpu_wr_en = wr; cpu_rd_en = !wr;
    for (int c = 0; c < 400; c++) begin
      flush = (c == flush_at);
      @(negedge clk);
      if (!cpu_stall) begin
        d = bytes_to_w(cpu_rdata);
        done = 1;
        break;
      end
      st++;
      @(posedge clk); #1;
    end
    chk("op_timeout", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    cpu_rd_en = 0; cpu_wr_en = 0; flush = 0;
  endtask

  task automatic chk_xfers(input int n0, input int nx, input logic [31:0] a, input bit wr,
                           input logic [31:0] wd);
    for (int k = 0; k < nx; k++) begin
      chk("xfer_addr", xq[n0+k].addr,
          wr ? (a - (a % 4)) : line_of(a) + 32'(4 * (k % W)));
      chk("xfer_we", {31'b0, xq[n0+k].we}, {31'b0, wr});
      if (wr) chk("xfer_wdata", xq[n0+k].data, wd);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input int flush_at);
    logic [31:0] d, base;
    int st, nx, n0, i, rc, exp_nx, exp_st;
    bit miss, flushed;
    base = line_of(a);
    i = idx_of(a);
    rc = W * (mem_lat + 1);
    miss = !(mvalid[i] && mline[i] == base) || (flush_at == 0);
    flushed = (flush_at == 0) || (miss && flush_at >= 1 && flush_at <= rc);
    exp_nx = !miss ? 0 : (flushed && flush_at >= 1) ? 2 * W : W;
    exp_st = (exp_nx / W) * (1 + rc);
    n0 = xq.size();
    run_op(0, a, '0, flush_at, d, st);
    nx = xq.size() - n0;
    chk({tag, "_rdata"}, d, ref_rd(a));
    chk({tag, "_stall"}, 32'(st), 32'(exp_st));
    chk({tag, "_xfers"}, 32'(nx), 32'(exp_nx));
    chk_xfers(n0, nx, a, 0, '0);
    if (flushed) for (int k = 0; k < NL; k++) mvalid[k] = 0;
    if (miss) begin
      mvalid[i] = 1;
      mline[i] = base;
    end
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] d;
    int st, nx, n0;
    n0 = xq.size();
    run_op(1, a, wd, -1, d, st);
    nx = xq.size() - n0;
    ref_mem[a - (a % 4)] = wd;
    chk({tag, "_stall"}, 32'(st), 32'(1 + mem_lat));
    chk({tag, "_xfers"}, 32'(nx), 32'd1);
    chk_xfers(n0, nx, a, 1, wd);
  endtask

  initial begin
    int n0, c;
    rst_b = 1; cpu_addr = 32'h100; cpu_rd_en = 1; cpu_wr_en = 0;
    cpu_wdata = '0; flush = 0;
    for (int k = 0; k < W; k++) begin
      phys_mem[32'h100 + 32'(4 * k)] = 32'h11111111 * 32'(k + 1);
      ref_mem[32'h100 + 32'(4 * k)]  = 32'h11111111 * 32'(k + 1);
    end
    for (int k = 0; k < NL; k++) begin mvalid[k] = 0; mline[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_cpu_rdata", bytes_to_w(cpu_rdata), 32'd0);
    @(posedge clk); #1;
    rst_b = 0; cpu_rd_en = 0;

    mem_lat = 2;
    do_read("cold_0x100", 32'h100, -1);
    do_read("hit_0x108", 32'h108, -1);
    do_write("st_hit_0x104", 32'h104, 32'hDEADBEEF);
    do_read("hit_0x104", 32'h104, -1);
    do_write("st_miss_0x800", 32'h800, 32'hCAFEF00D);
    do_read("noalloc_0x800", 32'h800, -1);

    do_read("conf_a", 32'h100, -1);
    do_read("conf_b", 32'h100 + 32'(4 * W * NL), -1);
    do_read("conf_a_again", 32'h100, -1);

    do_read("flush_refill", 32'h200, 5);

    // Reset pulsed one cycle after the second refill ack took effect.
    n0 = xq.size();
    cpu_addr = 32'h300; cpu_rd_en = 1;
    c = 0;
    while (xq.size() - n0 < 2 && c < 100) begin
      @(posedge clk); #3;
      c++;
    end
    chk("mid_rst_reach_2acks", 32'(xq.size() - n0), 32'd2);
    @(posedge clk); #1;
    rst_b = 1;
    #1;
    chk("mid_rst_req_drop", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    rst_b = 0; cpu_rd_en = 0; stray = 1;
    for (int k = 0; k < NL; k++) mvalid[k] = 0;
    @(negedge clk);
    chk("stray_ack_no_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    stray = 0;
    do_read("post_rst_0x300", 32'h300, -1);

    ack_hi = 1; mem_lat = 0;
    do_read("zw_read", 32'h1000, -1);
    do_write("zw_write", 32'h1004, 32'h0BADC0DE);
    do_read("zw_hit", 32'h1004, -1);
    ack_hi = 0;
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int kind;
      mem_lat = $urandom_range(0, 3);
      a = 32'h2000 + 32'($urandom_range(0, 3)) * 32'h400 + 32'($urandom_range(0, 1)) * 32'h10
          + 32'($urandom_range(0, W - 1)) * 4;
      kind = $urandom_range(0, 9);
      if (kind < 6)       do_read("rnd_read", a, -1);
      else if (kind < 9)  do_write("rnd_write", a, $urandom);
      else                do_read("rnd_flush_read", a, $urandom_range(0, W * (mem_lat + 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MIPS core's data port and a variable-latency main memory.
- The core sees byte-array data, big-endian word packing ({b[0],b[1],b[2],b[3]}), and a stall signal.
- Memory is accessed one word at a time through a req/ack handshake.

Parameters:
- NUM_LINES, 64, number of cache lines (power of 2, ≥2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_b  in  1  reset; asynchronous, active-high (1 = reset), name kept per codebase.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_rd_en  in  1  load request.
- cpu_wr_en  in  1  store request; has priority if both are asserted.
- cpu_wdata  in  8 x [0:3]  store data bytes.
- cpu_rdata  out  8 x [0:3]  load data bytes.
- cpu_stall  out  1  core must hold its request and PC.
- flush  in  1  invalidate all lines.
- mem_addr  out  32  word-aligned memory address.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_wdata  out  8 x [0:3]  write data.
- mem_rdata  in  8 x [0:3]  read data, valid with mem_ack.
- mem_ack  in  1  transfer completes this cycle.

Behaviour:
- Address split: offset = addr[OFF+1:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits. OFF = log2(WORDS_PER_LINE).
- hit = valid[index] & (tag_store[index] == tag).
- Reset (asynchronous): all valid bits 0, state IDLE, refill counter 0, flush_pend 0.
  - Outputs during reset: mem_req 0, mem_we 0, mem_addr 0, cpu_stall 0, cpu_rdata 0.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - Read hit: cpu_rdata driven combinationally from the data array in the same cycle; cpu_stall 0; zero-latency.
  - Read miss: cpu_stall 1 combinationally; next state REFILL; refill counter 0; latch line base = {tag, index, 0}.
  - Write (hit or miss): cpu_stall 1; next state WRITE; latch address and data.
  - No request: cpu_stall 0; cpu_rdata is don't-care (keep the last array read).
- REFILL:
  - mem_req 1, mem_we 0, mem_addr = line base + 4*counter.
  - On mem_ack: store mem_rdata into word[counter], then counter++.
  - On the ack for the last word: set valid and tag; go to IDLE.
  - The retried load then hits the following cycle, so read-miss latency is W memory transfers + 1 cycle.
  - cpu_stall 1 throughout.
- WRITE:
  - mem_req 1, mem_we 1, latched address/data.
  - On mem_ack: if the line still hits, update that word in the array (no allocate on miss); go to IDLE.
  - cpu_stall = ~mem_ack, so the core retires the store on the ack edge and never re-issues it.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req = 1.
  - Only one transfer is outstanding at a time.
  - mem_ack may arrive in the same cycle as mem_req is first asserted (zero wait).
  - mem_ack is ignored when mem_req = 0.
- flush:
  - In IDLE: all valid bits clear at the next edge. A same-cycle read is treated as a miss.
  - In REFILL/WRITE: set flush_pend; it is applied on entry to IDLE, after the refill's valid set, so the refilled line is also invalidated.
- Reset mid-REFILL/WRITE:
  - Immediate return to IDLE with mem_req 0.
  - A partially filled line stays invalid.
  - A late mem_ack after reset is ignored.
- Counter wrap: the refill counter is OFF bits wide and wraps to 0 on the last word.
- Line fill is always in word order 0..W-1 (no critical-word-first).

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, REFILL, WRITE).
  - localparams OFF_W, IDX_W, TAG_W as functions of the parameters.
  - byte_word_t type: 8-bit x [0:3].
  - pack/unpack functions between byte_word_t and 32-bit big-endian words.
- One sub-module, dcache_array:
  - Holds valid/tag/data storage with asynchronous read and synchronous word write.
  - Supports valid/tag set and clear-all.
- dcache_wt holds the FSM, refill counter, latches and muxing.

Test Plan:
- Cold read addr 0x100, memory words 0x11111111..0x44444444 at 0x100..0x10C, ack 2 cycles after each req:
  - 4 reads issued in order.
  - cpu_stall for 4*3+1 cycles, then rdata 0x11111111.
  - Read 0x108 next: hit, 0 stall, 0x33333333.
- Store 0xDEADBEEF to cached 0x104:
  - One mem write with ack.
  - cpu_stall drops on the ack cycle.
  - Read 0x104: hit, 0xDEADBEEF.
  - Store to uncached 0x800: memory written, line 0x800 not allocated (next read of 0x800 misses).
- Conflict: read 0x100, then 0x100 + 4*W*NUM_LINES (same index, different tag):
  - Second read misses and refills.
  - Re-read of 0x100 misses again.
- flush asserted during the REFILL of 0x200:
  - Refill completes and the stalled load returns data.
  - A subsequent read of 0x200 misses.
- rst_b pulsed after the 2nd refill ack:
  - mem_req drops in the same cycle.
  - Stray ack ignored.
  - Read of the same line performs a full 4-word refill.
- mem_ack held high permanently (zero wait): read miss completes with exactly W REFILL cycles; write completes with 1 stall cycle.
